multicycle_control: RTL and testbench

Multicycle MIPS main control FSM that sequences the shared datapath (single ALU, unified memory, register file, PC/IR) over 3-5 cycles per instruction. It decodes Opcode/Funct from the instruction register and drives the ALU_control code, mux selects and write strobes. It also stalls on a memory-ready handshake and counts retired instructions.

---
 rtl/mips_ctrl_pkg.sv | 40 ++++
 rtl/alu_decoder.sv | 20 ++
 rtl/multicycle_control.sv | 126 ++++++++++++
 tb/tb_multicycle_control.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: state encodings, opcode/funct values and control codes for the multicycle controller
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [3:0] ALU_ADD = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0011;
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps controller state and Funct to an ALU_control code and flags supported R-type functs
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] st,
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic       funct_ok
);
  logic [3:0] fn_code;
  always_comb begin
    fn_code = funct == FN_SUB ? ALU_SUB :
              funct == FN_AND ? ALU_AND :
              funct == FN_OR  ? ALU_OR  :
              funct == FN_SLT ? ALU_SLT : ALU_ADD;
    funct_ok = funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
               funct == FN_OR  || funct == FN_SLT;
    alu_control = st == EXEC ? fn_code : st == BRANCH ? ALU_SUB : ALU_ADD;
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS main control FSM with memory-ready stalls and a retired-instruction counter
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             Opcode,
  input  logic [5:0]             Funct,
  input  logic                   ZeroFlag,
  input  logic                   MemReady,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   MemtoReg,
  output logic                   RegDst,
  output logic                   RegWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             PCSource,
  output logic                   PCWriteEn,
  output logic [3:0]             ALU_control,
  output logic                   IllegalOp,
  output logic [3:0]             State,
  output logic [COUNT_WIDTH-1:0] InstrCount
);
  logic [3:0] st, nxt, dec_alu;
  logic       funct_ok, retire;
  alu_decoder u_alu_decoder (
    .st          (st),
    .funct       (Funct),
    .alu_control (dec_alu),
    .funct_ok    (funct_ok)
  );
  always_ff @(posedge clk) begin
    if (reset) st <= FETCH;
    else st <= nxt;
  end
  always_comb begin
    nxt = FETCH;
    case (st)
      FETCH:  nxt = MemReady ? DECODE : FETCH;
      DECODE: nxt = (Opcode == OP_LW || Opcode == OP_SW) ? MEMADR :
                    (Opcode == OP_RTYPE && funct_ok)     ? EXEC   :
                    Opcode == OP_BEQ                     ? BRANCH :
                    Opcode == OP_J                       ? JUMP   :
                    Opcode == OP_ADDI                    ? ADDIEX : FETCH;
      MEMADR: nxt = Opcode == OP_SW ? MEMWR : MEMRD;
      MEMRD:  nxt = MemReady ? MEMWB : MEMRD;
      MEMWR:  nxt = MemReady ? FETCH : MEMWR;
      EXEC:   nxt = ALUWB;
      ADDIEX: nxt = ADDIWB;
      default: nxt = FETCH;
    endcase
  end
  always_comb begin
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    MemtoReg  = 1'b0;
    RegDst    = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_B;
    PCSource  = PC_ALU;
    PCWriteEn = 1'b0;
    if (!reset)
      case (st)
        FETCH: begin
          MemRead   = 1'b1;
          ALUSrcB   = SRCB_4;
          IRWrite   = MemReady;
          PCWriteEn = MemReady;
        end
        DECODE: ALUSrcB = SRCB_IMM_SH;
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        EXEC: ALUSrcA = 1'b1;
        ALUWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        BRANCH: begin
          ALUSrcA   = 1'b1;
          PCSource  = PC_ALUOUT;
          PCWriteEn = ZeroFlag;
        end
        JUMP: begin
          PCSource  = PC_JUMP;
          PCWriteEn = 1'b1;
        end
        ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        ADDIWB: RegWrite = 1'b1;
        default: ;
      endcase
  end
  assign ALU_control = reset ? ALU_ADD : dec_alu;
  assign IllegalOp   = !reset && st == DECODE && nxt == FETCH;
  assign retire      = nxt == FETCH && (st == MEMWB || st == MEMWR || st == ALUWB ||
                                        st == BRANCH || st == JUMP || st == ADDIWB);
  assign State       = st;
  always_ff @(posedge clk) begin
    if (reset) InstrCount <= '0;
    else InstrCount <= InstrCount + {{(COUNT_WIDTH-1){1'b0}}, retire};
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed self-checking bench for the multicycle controller (4-bit counter build)
module tb_multicycle_control;
  logic       clk, reset, ZeroFlag, MemReady;
  logic [5:0] Opcode, Funct;
  logic       IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, PCWriteEn, IllegalOp;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] ALU_control, State, InstrCount;
  int checks, failures;
  multicycle_control #(.COUNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .ZeroFlag(ZeroFlag), .MemReady(MemReady),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .PCWriteEn(PCWriteEn), .ALU_control(ALU_control), .IllegalOp(IllegalOp), .State(State),
    .InstrCount(InstrCount)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic set(input logic [5:0] op, input logic [5:0] fn, input logic rdy, input logic z);
    Opcode = op;
    Funct = fn;
    MemReady = rdy;
    ZeroFlag = z;
    #1;
  endtask
  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    set(6'b000000, 6'b100000, 1'b1, 1'b1);
    chk("rst_memread", MemRead, 0);
    chk("rst_irwrite", IRWrite, 0);
    chk("rst_pcwe", PCWriteEn, 0);
    chk("rst_alu", ALU_control, 4'b0101);
    chk("rst_illegal", IllegalOp, 0);
    cyc();
    chk("rst_state", State, 0);
    chk("rst_count", InstrCount, 0);
    reset = 1'b0;
    set(6'b000000, 6'b100000, 1'b1, 1'b0);
    chk("add_fetch_state", State, 0);
    chk("add_fetch_irw", IRWrite, 1);
    chk("add_fetch_srcb", ALUSrcB, 2'b01);
    cyc();
    chk("add_dec_state", State, 1);
    chk("add_dec_srcb", ALUSrcB, 2'b11);
    chk("add_dec_illegal", IllegalOp, 0);
    cyc();
    chk("add_exec_state", State, 6);
    chk("add_exec_alu", ALU_control, 4'b0101);
    chk("add_exec_srca", ALUSrcA, 1);
    cyc();
    chk("add_wb_state", State, 7);
    chk("add_wb_regwrite", RegWrite, 1);
    chk("add_wb_regdst", RegDst, 1);
    chk("add_wb_count", InstrCount, 0);
    cyc();
    chk("add_done_state", State, 0);
    chk("add_done_count", InstrCount, 1);
    set(6'b100011, 6'b000000, 1'b0, 1'b0);
    chk("lw_f1_irw", IRWrite, 0);
    cyc();
    chk("lw_f2_state", State, 0);
    chk("lw_f2_irw", IRWrite, 0);
    cyc();
    chk("lw_f3_irw", IRWrite, 0);
    cyc();
    set(6'b100011, 6'b000000, 1'b1, 1'b0);
    chk("lw_f4_state", State, 0);
    chk("lw_f4_irw", IRWrite, 1);
    cyc();
    chk("lw_dec_state", State, 1);
    cyc();
    chk("lw_adr_state", State, 2);
    chk("lw_adr_srcb", ALUSrcB, 2'b10);
    set(6'b100011, 6'b000000, 1'b0, 1'b0);
    cyc();
    chk("lw_rd1_state", State, 3);
    chk("lw_rd1_iord", IorD, 1);
    chk("lw_rd1_memread", MemRead, 1);
    chk("lw_rd1_regwrite", RegWrite, 0);
    cyc();
    chk("lw_rd2_state", State, 3);
    cyc();
    set(6'b100011, 6'b000000, 1'b1, 1'b0);
    chk("lw_rd3_state", State, 3);
    cyc();
    chk("lw_wb_state", State, 4);
    chk("lw_wb_memtoreg", MemtoReg, 1);
    chk("lw_wb_regwrite", RegWrite, 1);
    cyc();
    chk("lw_count", InstrCount, 2);
    set(6'b000100, 6'b000000, 1'b1, 1'b1);
    cyc();
    cyc();
    chk("beq1_state", State, 8);
    chk("beq1_pcwe", PCWriteEn, 1);
    chk("beq1_pcsrc", PCSource, 2'b01);
    chk("beq1_alu", ALU_control, 4'b0110);
    cyc();
    set(6'b000100, 6'b000000, 1'b1, 1'b0);
    cyc();
    cyc();
    chk("beq2_state", State, 8);
    chk("beq2_pcwe", PCWriteEn, 0);
    cyc();
    chk("beq_count", InstrCount, 4);
    set(6'b001000, 6'b000000, 1'b1, 1'b0);
    cyc();
    cyc();
    chk("addi_ex_state", State, 10);
    chk("addi_ex_srcb", ALUSrcB, 2'b10);
    cyc();
    chk("addi_wb_state", State, 11);
    chk("addi_wb_regwrite", RegWrite, 1);
    chk("addi_wb_regdst", RegDst, 0);
    cyc();
    chk("addi_count", InstrCount, 5);
    set(6'b000000, 6'b101010, 1'b1, 1'b0);
    cyc();
    cyc();
    chk("slt_exec_alu", ALU_control, 4'b0011);
    cyc();
    cyc();
    chk("slt_count", InstrCount, 6);
    set(6'b111111, 6'b100000, 1'b1, 1'b0);
    cyc();
    chk("ill1_pulse", IllegalOp, 1);
    cyc();
    chk("ill1_state", State, 0);
    chk("ill1_pulse_end", IllegalOp, 0);
    chk("ill1_count", InstrCount, 6);
    set(6'b000000, 6'b000111, 1'b1, 1'b0);
    cyc();
    chk("ill2_pulse", IllegalOp, 1);
    cyc();
    chk("ill2_state", State, 0);
    chk("ill2_count", InstrCount, 6);
    set(6'b101011, 6'b000000, 1'b1, 1'b0);
    cyc();
    cyc();
    set(6'b101011, 6'b000000, 1'b0, 1'b0);
    cyc();
    chk("sw_state", State, 5);
    chk("sw_memwrite", MemWrite, 1);
    chk("sw_memread", MemRead, 0);
    reset = 1'b1;
    #1;
    chk("sw_rst_memwrite", MemWrite, 0);
    chk("sw_rst_iord", IorD, 0);
    cyc();
    chk("sw_rst_state", State, 0);
    chk("sw_rst_count", InstrCount, 0);
    reset = 1'b0;
    set(6'b000010, 6'b000000, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      cyc();
      cyc();
      if (i == 0) begin
        chk("j_state", State, 9);
        chk("j_pcwe", PCWriteEn, 1);
        chk("j_pcsrc", PCSource, 2'b10);
      end
      cyc();
      if (i == 14) chk("j_count_max", InstrCount, 15);
    end
    chk("j_count_wrap", InstrCount, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
